// File: rtl/sw_debounce_sb_ctrl.sv
// Switch-input peripheral: per-bit synchroniser and debouncer, sticky change flags, maskable level IRQ.
// Reads are a same-cycle mux and writes land on the clock edge; the bus never stalls.
module sw_debounce_sb_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [31:0]         addr_i,
  input  logic                req_i,
  input  logic                WE_i,
  input  logic [31:0]         WD_i,
  output logic [31:0]         RD_o,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] ADDR_STATE  = 32'h0000_0000;
  localparam logic [31:0] ADDR_RAW    = 32'h0000_0004;
  localparam logic [31:0] ADDR_CHANGE = 32'h0000_0008;
  localparam logic [31:0] ADDR_IRQ_EN = 32'h0000_000C;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0010;

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sync_q, sync_d;
  logic [SW_WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [SW_WIDTH-1:0]                  state_q, state_d;
  logic [SW_WIDTH-1:0]                  change_q, change_d;
  logic [SW_WIDTH-1:0]                  irq_en_q, irq_en_d;
  logic                                 ctrl_q, ctrl_d;
  logic                                 irq_q, irq_d;

  logic [SW_WIDTH-1:0] sync;
  logic [SW_WIDTH-1:0] set_vec;
  logic [SW_WIDTH-1:0] clr_vec;
  logic [31:0]         rd_mux;
  logic                wr_en, rd_en;
  logic                sel_state, sel_raw, sel_change, sel_irq_en, sel_ctrl;
  logic                unused_wd;

  assign wr_en = req_i & WE_i;
  assign rd_en = req_i & ~WE_i;

  assign sel_state  = (addr_i == ADDR_STATE);
  assign sel_raw    = (addr_i == ADDR_RAW);
  assign sel_change = (addr_i == ADDR_CHANGE);
  assign sel_irq_en = (addr_i == ADDR_IRQ_EN);
  assign sel_ctrl   = (addr_i == ADDR_CTRL);

  // Write-data bits above the register widths are don't-care.
  assign unused_wd = ^WD_i;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sw_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // The count never passes CNT_LAST: reaching it either commits the new level or an agreeing cycle clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_vec = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      if (sync[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        state_d[i] = sync[i];
        cnt_d[i]   = '0;
        set_vec[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // OR-ing set_vec after the W1C mask lets a same-cycle debounce event win over a clear.
  always_comb begin
    clr_vec  = '0;
    irq_en_d = irq_en_q;
    ctrl_d   = ctrl_q;
    if (wr_en && sel_change) begin
      clr_vec = WD_i[SW_WIDTH-1:0];
    end
    if (wr_en && sel_irq_en) begin
      irq_en_d = WD_i[SW_WIDTH-1:0];
    end
    if (wr_en && sel_ctrl) begin
      ctrl_d = WD_i[0];
    end
    change_d = (change_q & ~clr_vec) | set_vec;
    irq_d    = ctrl_d & (|(change_d & irq_en_d));
  end

  always_comb begin
    rd_mux = '0;
    if (rd_en) begin
      if (sel_state) begin
        rd_mux[SW_WIDTH-1:0] = state_q;
      end else if (sel_raw) begin
        rd_mux[SW_WIDTH-1:0] = sync;
      end else if (sel_change) begin
        rd_mux[SW_WIDTH-1:0] = change_q;
      end else if (sel_irq_en) begin
        rd_mux[SW_WIDTH-1:0] = irq_en_q;
      end else if (sel_ctrl) begin
        rd_mux[0] = ctrl_q;
      end
    end
  end

  assign RD_o  = rd_mux;
  assign irq_o = irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      state_q  <= '0;
      change_q <= '0;
      irq_en_q <= '0;
      ctrl_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      change_q <= change_d;
      irq_en_q <= irq_en_d;
      ctrl_q   <= ctrl_d;
      irq_q    <= irq_d;
    end
  end

endmodule
